// File: rtl/duc_pkg.sv
// Shared constants and FSM encoding for the DUC coefficient loader.
// The readback option is enabled with the DUC_COEF_READBACK_EN macro (see duc_coef_loader).
package duc_pkg;

    localparam int NUM_TAPS       = 40;
    localparam int INTERP         = 4;
    localparam int TAPS_PER_PHASE = NUM_TAPS / INTERP;
    localparam int COEF_W         = 16;
    localparam int ADDR_W         = 16;
    localparam int BANK_AW        = 6;
    localparam int TAP_W          = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAP  = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/duc_coef_bank.sv
// 40-entry coefficient register file: one synchronous write port, one
// combinational read port that returns zero for addresses past the last tap.
module duc_coef_bank
    import duc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [BANK_AW-1:0] wr_addr,
    input  logic [COEF_W-1:0]  wr_data,
    input  logic [BANK_AW-1:0] rd_addr,
    output logic [COEF_W-1:0]  rd_data
);

    logic [COEF_W-1:0] mem [NUM_TAPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wr_addr < BANK_AW'(NUM_TAPS))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (rd_addr < BANK_AW'(NUM_TAPS)) ? mem[rd_addr] : '0;

endmodule

// File: rtl/duc_coef_loader.sv
// Double-buffered coefficient store feeding per-phase 10-tap bursts to the DUC filter.
// Define DUC_COEF_READBACK_EN to add the shadow-bank readback port (rb_addr/rb_data).
module duc_coef_loader
    import duc_pkg::*;
(
    input  logic              clkin,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              wr_rst,
    input  logic              commit,
    input  logic              req_valid,
    input  logic [1:0]        req_phase,
    output logic              req_ready,
    output logic              coef_valid,
    output logic [COEF_W-1:0] coef_data,
    output logic [TAP_W-1:0]  coef_tap,
    output logic              coef_last,
    output logic              shadow_full,
    output logic              swap_done,
    output logic              commit_err,
    output logic              addr_err,
`ifdef DUC_COEF_READBACK_EN
    input  logic [BANK_AW-1:0] rb_addr,
    output logic [COEF_W-1:0]  rb_data,
`endif
    output state_t            dbg_state
);

    state_t              state;
    logic                active_sel;
    logic                commit_pending;
    logic [NUM_TAPS-1:0] bitmap;
    logic [NUM_TAPS-1:0] bitmap_next;
    logic [1:0]          phase;
    logic [TAP_W-1:0]    t;
    logic                wr_ok;
    logic [BANK_AW-1:0]  act_rd_addr;
    logic [BANK_AW-1:0]  shd_rd_addr;
    logic [BANK_AW-1:0]  rd_addr0;
    logic [BANK_AW-1:0]  rd_addr1;
    logic [COEF_W-1:0]   rd_data0;
    logic [COEF_W-1:0]   rd_data1;
    logic [COEF_W-1:0]   active_data;

    assign wr_ok = wr_en && (wr_addr < ADDR_W'(NUM_TAPS));

    // Handshake: a burst request transfers on a cycle where req_valid && req_ready;
    // req_ready is high only in IDLE with no swap pending, and tap 0 follows next cycle.
    assign req_ready = (state == IDLE) && !commit_pending;
    assign dbg_state = state;

    // Coefficient n lives at {tap, phase}; in IDLE the requested phase is read
    // directly so tap 0 can be registered on the accepting edge.
    assign act_rd_addr = (state == BURST) ? {t, phase} : {TAP_W'(0), req_phase};

`ifdef DUC_COEF_READBACK_EN
    assign shd_rd_addr = rb_addr;
`else
    assign shd_rd_addr = '0;
`endif

    assign rd_addr0    = active_sel ? shd_rd_addr : act_rd_addr;
    assign rd_addr1    = active_sel ? act_rd_addr : shd_rd_addr;
    assign active_data = active_sel ? rd_data1 : rd_data0;

    duc_coef_bank u_bank0 (
        .clk     (clkin),
        .rst     (reset),
        .we      (wr_ok && active_sel),
        .wr_addr (wr_addr[BANK_AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr0),
        .rd_data (rd_data0)
    );

    duc_coef_bank u_bank1 (
        .clk     (clkin),
        .rst     (reset),
        .we      (wr_ok && !active_sel),
        .wr_addr (wr_addr[BANK_AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr1),
        .rd_data (rd_data1)
    );

    // Clearing (wr_rst or a swap) wins over a same-cycle write's bitmap update.
    always_comb begin
        bitmap_next = bitmap;
        if (wr_ok) begin
            bitmap_next[wr_addr[BANK_AW-1:0]] = 1'b1;
        end
        if (wr_rst || (state == SWAP)) begin
            bitmap_next = '0;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            active_sel     <= 1'b0;
            commit_pending <= 1'b0;
            bitmap         <= '0;
            shadow_full    <= 1'b0;
            phase          <= '0;
            t              <= '0;
            coef_valid     <= 1'b0;
            coef_data      <= '0;
            coef_tap       <= '0;
            coef_last      <= 1'b0;
            swap_done      <= 1'b0;
            commit_err     <= 1'b0;
            addr_err       <= 1'b0;
        end else begin
            bitmap      <= bitmap_next;
            shadow_full <= &bitmap_next;
            swap_done   <= 1'b0;
            commit_err  <= 1'b0;

            if (wr_rst) begin
                addr_err <= 1'b0;
            end
            if (wr_en && !wr_ok) begin
                addr_err <= 1'b1;
            end

            if (commit && !commit_pending && !shadow_full) begin
                commit_err <= 1'b1;
            end
            if (wr_rst) begin
                commit_pending <= 1'b0;
            end else if (commit && shadow_full) begin
                commit_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    coef_valid <= 1'b0;
                    coef_last  <= 1'b0;
                    coef_tap   <= '0;
                    coef_data  <= '0;
                    if (commit_pending) begin
                        state <= SWAP;
                    end else if (req_valid) begin
                        phase      <= req_phase;
                        coef_valid <= 1'b1;
                        coef_data  <= active_data;
                        t          <= TAP_W'(1);
                        state      <= BURST;
                    end
                end
                SWAP: begin
                    active_sel     <= ~active_sel;
                    commit_pending <= 1'b0;
                    swap_done      <= 1'b1;
                    state          <= IDLE;
                end
                BURST: begin
                    if (t == TAP_W'(TAPS_PER_PHASE)) begin
                        coef_valid <= 1'b0;
                        coef_last  <= 1'b0;
                        coef_tap   <= '0;
                        coef_data  <= '0;
                        t          <= '0;
                        state      <= IDLE;
                    end else begin
                        coef_data <= active_data;
                        coef_tap  <= t;
                        coef_last <= (t == TAP_W'(TAPS_PER_PHASE - 1));
                        t         <= t + TAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DUC_COEF_READBACK_EN
    logic [COEF_W-1:0] shadow_data;
    assign shadow_data = active_sel ? rd_data0 : rd_data1;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            rb_data <= '0;
        end else begin
            rb_data <= shadow_data;
        end
    end
`endif

endmodule

// File: tb/tb_duc_coef_loader.sv
// Bench for duc_coef_loader: directed plan sequences, a write/error vector table
// and randomized operations checked against an array-level bank model.
module tb_duc_coef_loader;
    import duc_pkg::*;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_rst = 1'b0;
    logic        commit = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_phase = '0;
    logic        req_ready;
    logic        coef_valid;
    logic [15:0] coef_data;
    logic [3:0]  coef_tap;
    logic        coef_last;
    logic        shadow_full;
    logic        swap_done;
    logic        commit_err;
    logic        addr_err;
    state_t      dbg_state;
`ifdef DUC_COEF_READBACK_EN
    logic [5:0]  rb_addr = '0;
    logic [15:0] rb_data;
`endif

    duc_coef_loader dut (
        .clkin       (clkin),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_rst      (wr_rst),
        .commit      (commit),
        .req_valid   (req_valid),
        .req_phase   (req_phase),
        .req_ready   (req_ready),
        .coef_valid  (coef_valid),
        .coef_data   (coef_data),
        .coef_tap    (coef_tap),
        .coef_last   (coef_last),
        .shadow_full (shadow_full),
        .swap_done   (swap_done),
        .commit_err  (commit_err),
        .addr_err    (addr_err),
`ifdef DUC_COEF_READBACK_EN
        .rb_addr     (rb_addr),
        .rb_data     (rb_data),
`endif
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clkin = ~clkin;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad = 0;

    // reference model: whole banks as arrays, swapped by exchange
    logic [15:0] act_m [40];
    logic [15:0] shd_m [40];
    bit          written_m [40];
    bit          addr_err_m;
    bit          pending_m;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        bit          rst;
        bit          exp_err;
        bit          exp_full;
    } vec_t;

    vec_t tbl [6];

    function automatic bit model_full();
        for (int i = 0; i < 40; i++) begin
            if (!written_m[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 40; i++) begin
            act_m[i] = '0;
            shd_m[i] = '0;
            written_m[i] = 1'b0;
        end
        addr_err_m = 1'b0;
        pending_m = 1'b0;
    endfunction

    function automatic void model_swap();
        logic [15:0] tmp;
        for (int i = 0; i < 40; i++) begin
            tmp = act_m[i];
            act_m[i] = shd_m[i];
            shd_m[i] = tmp;
            written_m[i] = 1'b0;
        end
        pending_m = 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // driver tasks
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit rst_too);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_rst = rst_too;
        tick();
        wr_en = 1'b0; wr_rst = 1'b0;
        if (rst_too) begin
            for (int i = 0; i < 40; i++) written_m[i] = 1'b0;
            addr_err_m = 1'b0;
            pending_m = 1'b0;
        end
        if (a < 16'd40) begin
            shd_m[a] = d;
            if (!rst_too) written_m[a] = 1'b1;
        end else begin
            addr_err_m = 1'b1;
        end
        check("wr_addr_err", addr_err, addr_err_m);
        check("wr_shadow_full", shadow_full, model_full());
    endtask

    task automatic do_rst();
        wr_rst = 1'b1;
        tick();
        wr_rst = 1'b0;
        for (int i = 0; i < 40; i++) written_m[i] = 1'b0;
        addr_err_m = 1'b0;
        pending_m = 1'b0;
        check("rst_addr_err", addr_err, 0);
        check("rst_shadow_full", shadow_full, 0);
    endtask

    task automatic load_all(input int base);
        for (int n = 0; n < 40; n++) do_write(16'(n), 16'(base + n), 1'b0);
    endtask

    task automatic expect_swap(input bit exp_swap);
        int cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            if (swap_done) cnt++;
        end
        check("swap_done_count", cnt, exp_swap);
        if (exp_swap) begin
            model_swap();
            check("post_swap_full", shadow_full, 0);
        end
    endtask

    task automatic do_commit();
        bit full = model_full();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("commit_err", commit_err, !full);
        expect_swap(full);
    endtask

    // scoreboard: expected burst is queued from the model before the request
    task automatic burst(input logic [1:0] ph, input int commit_at);
        logic [15:0] exp_q[$];
        int n = 0;
        for (int k = 0; k < 10; k++) exp_q.push_back(act_m[int'(ph) + 4 * k]);
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            check("req_ready_wait", req_ready, 1);
            return;
        end
        req_valid = 1'b1; req_phase = ph;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("coef_valid", coef_valid, 1);
            check("coef_tap", coef_tap, k);
            check("coef_last", coef_last, k == 9);
            check("coef_data", coef_data, exp_q.pop_front());
            check("req_ready_busy", req_ready, 0);
            if (k == commit_at) commit = 1'b1;
            tick();
            commit = 1'b0;
            if (k == commit_at && model_full()) pending_m = 1'b1;
        end
        check("gap_valid", coef_valid, 0);
        check("gap_ready", req_ready, !pending_m);
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'd40,   16'h0001, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 16'hFFFF, 16'h0002, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 16'd0,    16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 16'd0,    16'h4242, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'd0,    16'h1234, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 16'd64,   16'hBEEF, 1'b0, 1'b1, 1'b0};

        model_reset();
        repeat (2) @(posedge clkin);
        #3 reset = 1'b0;
        tick();

        // 1: reset state and an all-zero burst
        check("rst_req_ready", req_ready, 1);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_coef_data", coef_data, 0);
        check("rst_shadow_full", shadow_full, 0);
        check("rst_swap_done", swap_done, 0);
        check("rst_commit_err", commit_err, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_state", dbg_state, 0);
        burst(2'd2, -1);

        // 2: full load, commit, phase 1 burst
        load_all(1000);
        do_commit();
        burst(2'd1, -1);

        // 3: partial load, rejected commit, active bank untouched
        for (int n = 0; n < 39; n++) do_write(16'(n), 16'(2000 + n), 1'b0);
        do_commit();
        burst(2'd0, -1);

        // 4: commit lands mid-burst at tap 3
        do_write(16'd39, 16'd3039, 1'b0);
        burst(2'd0, 3);
        expect_swap(1'b1);
        burst(2'd3, -1);

        // 5: out-of-range writes and wr_rst via vector table
        load_all(4000);
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].wr) do_write(tbl[i].a, tbl[i].d, tbl[i].rst);
            else do_rst();
            check("tbl_addr_err", addr_err, tbl[i].exp_err);
            check("tbl_shadow_full", shadow_full, tbl[i].exp_full);
        end
        for (int n = 1; n < 40; n++) do_write(16'(n), 16'(5000 + n), 1'b0);
        do_commit();
        burst(2'd0, -1);

        // 6: reset at tap 5
        req_valid = 1'b1; req_phase = 2'd1;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("pre_abort_tap", coef_tap, 5);
        reset = 1'b1;
        #1;
        check("abort_valid", coef_valid, 0);
        check("abort_ready", req_ready, 1);
        #2 reset = 1'b0;
        model_reset();
        tick();
        burst(2'd1, -1);

        // randomized operations against the model
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_write(16'($urandom_range(0, 47)), 16'($urandom), 1'b0);
                4:          do_rst();
                5, 6:       do_commit();
                7, 8:       burst(2'($urandom_range(0, 3)), -1);
                default:    load_all(int'($urandom_range(0, 60000)));
            endcase
        end
        burst(2'($urandom_range(0, 3)), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/duc_coef_loader.md
Name: duc_coef_loader

Overview:
- Upstream coefficient stage for the fixed 4x interpolating DUC filter.
- Accepts host writes of the 40 interpolation coefficients into a shadow bank.
- Swaps the shadow bank into the active bank only on a validated commit, and only at a burst boundary.
- Streams per-phase coefficient bursts (10 taps per phase) to the DSP48 systolic chain on request.

Parameters:
- NUM_TAPS, 40, total coefficient count.
- INTERP, 4, interpolation factor (number of polyphase branches).
- TAPS_PER_PHASE, NUM_TAPS/INTERP = 10, taps per phase burst.
- COEF_W, 16, coefficient width (signed two's complement).
- ADDR_W, 16, host write address width.

Ports:
- clkin  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe, one write per cycle.
- wr_addr  in  ADDR_W  coefficient index n; coefficient n belongs to phase n mod 4, tap n div 4.
- wr_data  in  COEF_W  coefficient value.
- wr_rst  in  1  clears the shadow written-bitmap (restarts a load).
- commit  in  1  one-cycle request to activate the shadow bank.
- req_valid  in  1  filter requests a phase burst.
- req_phase  in  2  requested phase 0..3.
- req_ready  out  1  request accepted when req_valid && req_ready.
- coef_valid  out  1  coef_data valid.
- coef_data  out  COEF_W  active coefficient.
- coef_tap  out  4  tap index 0..9 within the burst.
- coef_last  out  1  high with tap 9.
- shadow_full  out  1  all 40 shadow addresses written since the last wr_rst or swap.
- swap_done  out  1  one-cycle pulse when the active bank changes.
- commit_err  out  1  one-cycle pulse when a commit is rejected.
- addr_err  out  1  sticky; set on a write with wr_addr >= NUM_TAPS; cleared by wr_rst.

Behaviour:
Reset:
- Both banks are all zero and active_sel = 0.
- The bitmap is zero and commit_pending = 0.
- State is IDLE.
- All outputs are 0 except req_ready = 1.

Writes:
- wr_en with addr < 40 writes shadow[addr] and sets bitmap[addr]. Rewriting an address overwrites it.
- A write with addr >= 40 is dropped and sets addr_err.
- Writes are accepted in every state and never touch the active bank.

wr_rst:
- Clears the bitmap and addr_err. Shadow contents are kept.
- If wr_rst and wr_en occur in the same cycle, the bitmap clear wins but the data write still occurs.
- wr_rst also cancels commit_pending.

shadow_full:
- Equals the AND-reduction of the bitmap, registered (one cycle after the 40th distinct write).

Commit:
- commit with shadow_full = 1 sets commit_pending.
- commit with shadow_full = 0 pulses commit_err the next cycle; no state change.
- A commit while a commit is already pending is ignored.

FSM states IDLE, SWAP, BURST:
- IDLE:
  - If commit_pending, go to SWAP and drive req_ready = 0. A swap takes priority over a simultaneous req_valid.
  - Otherwise req_ready = 1. On req_valid, latch the phase, set t = 0 and go to BURST.
- SWAP (1 cycle):
  - Toggle active_sel, clear the bitmap and commit_pending.
  - Pulse swap_done, return to IDLE.
  - The new shadow is the old active bank; its contents are retained but it is marked empty.
- BURST:
  - Each cycle, coef_data is registered from active[phase + 4*t], with coef_valid = 1, coef_tap = t and coef_last = (t == 9).
  - The first coefficient appears the cycle after acceptance.
  - After t = 9, return to IDLE. req_ready stays low for the whole burst.
  - A burst completes uninterrupted: a commit arriving mid-burst only sets pending.
  - Back-to-back bursts have a 1-cycle IDLE gap.
- Asserting reset mid-burst aborts the burst immediately and returns all registers to reset values.

Optional Feature:
- Macro: DUC_COEF_READBACK_EN.
- Defined: adds ports rb_addr (in, 6) and rb_data (out, COEF_W).
  - rb_data is registered from shadow[rb_addr] with 1-cycle latency.
  - Out-of-range rb_addr returns 0.
  - rb_data resets to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package duc_pkg:
  - constants NUM_TAPS, INTERP, TAPS_PER_PHASE, COEF_W;
  - FSM state encoding (IDLE = 0, SWAP = 1, BURST = 2).
- Sub-module duc_coef_bank: a 40 x COEF_W register file with a write port and a combinational read port, async-reset to zero. It is instantiated twice; banks are selected by active_sel.

Test Plan:
1. Reset, then req phase 2 -> 10 cycles of coef_valid with coef_data = 0 and coef_tap 0..9; coef_last only on tap 9.
2. Write addr n = 1000+n for n = 0..39, commit -> shadow_full = 1, swap_done pulses once. A phase 1 burst then yields 1001, 1005, ..., 1037.
3. Write only addresses 0..38, commit -> commit_err pulses, no swap_done; phase 0 burst data unchanged.
4. Full load, commit asserted at burst tap 3 -> current burst finishes with the old values, swap occurs in the next IDLE, the following burst uses the new values.
5. Write addr 40 and addr 0xFFFF -> addr_err is set, shadow and bitmap are unchanged; wr_rst clears addr_err.
6. Assert reset at tap 5 of a burst -> coef_valid drops immediately, req_ready = 1, and a subsequent burst returns all zeros.
